// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared types and default 12 MHz timing for the WS2812 serialiser.
//   state_e       top-level FSM states
//   grb_t         one LED's colour in wire order (green, red, blue)
//   *_DEF         default protocol timing in 12 MHz cycles
package ws2812_pkg;

    localparam int unsigned COLOR_W      = 8;
    localparam int unsigned BITS_PER_LED = 24;
    localparam int unsigned BIT_W        = 5;

    localparam int unsigned T0H_DEF    = 5;     // 417 ns
    localparam int unsigned T1H_DEF    = 10;    // 833 ns
    localparam int unsigned TBIT_DEF   = 15;    // 1.25 us
    localparam int unsigned TLATCH_DEF = 3600;  // 300 us

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_e;

    typedef struct packed {
        logic [COLOR_W-1:0] green;
        logic [COLOR_W-1:0] red;
        logic [COLOR_W-1:0] blue;
    } grb_t;

endpackage

// File: rtl/ws2812_if.sv
// ws2812_if: colour input handshake.
//   red/green/blue  colour levels, sampled when in_valid && in_ready
//   in_valid        upstream has a colour
//   in_ready        driver can accept a colour
interface ws2812_if;
    import ws2812_pkg::*;

    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
    logic               in_valid;
    logic               in_ready;

    modport master (output red, green, blue, in_valid, input in_ready);
    modport slave  (input red, green, blue, in_valid, output in_ready);

endinterface

// File: rtl/ws2812_bit_tx.sv
// ws2812_bit_tx: generates one WS2812 bit waveform of TBIT cycles.
//   clk12MHz, reset  clock and synchronous active-high reset
//   start            begin a new bit on this edge (may coincide with done_c)
//   bit_val          value of the bit being started / in progress
//   done_c           combinational, high on the last cycle of a bit
//   dout             registered line output, aligned with the bit cycle count
module ws2812_bit_tx #(
    parameter int unsigned T0H   = 5,
    parameter int unsigned T1H   = 10,
    parameter int unsigned TBIT  = 15,
    parameter int unsigned CNT_W = 4
) (
    input  logic clk12MHz,
    input  logic reset,
    input  logic start,
    input  logic bit_val,
    output logic done_c,
    output logic dout
);

    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic             run_q, run_d;
    logic             dout_q, dout_d;

    // State register
    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            cyc_cnt_q <= '0;
            run_q     <= 1'b0;
            dout_q    <= 1'b0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
            run_q     <= run_d;
            dout_q    <= dout_d;
        end
    end

    // Bit timing; dout is computed from the next count so it lines up with it
    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        run_d     = run_q;
        done_c    = run_q && (cyc_cnt_q == CNT_W'(TBIT - 1));

        if (start) begin
            run_d     = 1'b1;
            cyc_cnt_d = '0;
        end else if (done_c) begin
            run_d     = 1'b0;
            cyc_cnt_d = '0;
        end else if (run_q) begin
            cyc_cnt_d = cyc_cnt_q + 1'b1;
        end

        dout_d = run_d && (cyc_cnt_d < (bit_val ? CNT_W'(T1H) : CNT_W'(T0H)));
    end

    assign dout = dout_q;

endmodule

// File: rtl/ws2812_driver.sv
// ws2812_driver: sends one captured colour to a chain of NUM_LEDS WS2812 LEDs,
// then holds the line low for TLATCH cycles.
//   clk12MHz, reset  12 MHz clock, synchronous active-high reset
//   bus              colour handshake (slave side)
//   dout             WS2812 data line, registered
//   busy             high while sending or latching
module ws2812_driver
    import ws2812_pkg::*;
#(
    parameter int unsigned NUM_LEDS = 1,
    parameter int unsigned T0H      = T0H_DEF,
    parameter int unsigned T1H      = T1H_DEF,
    parameter int unsigned TBIT     = TBIT_DEF,
    parameter int unsigned TLATCH   = TLATCH_DEF
) (
    input  logic    clk12MHz,
    input  logic    reset,
    ws2812_if.slave bus,
    output logic    dout,
    output logic    busy
);

    localparam int unsigned CNT_MAX = (TBIT > TLATCH) ? TBIT : TLATCH;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam int unsigned LED_W   = $clog2(NUM_LEDS + 1);

    state_e                  state_q, state_d;
    logic [BITS_PER_LED-1:0] shreg_q, shreg_d;
    grb_t                    copy_q, copy_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [LED_W-1:0]        led_cnt_q, led_cnt_d;
    logic [CNT_W-1:0]        lat_cnt_q, lat_cnt_d;
    logic                    in_ready_q, in_ready_d;
    logic                    busy_q, busy_d;

    logic accept_c;
    logic tx_start_c;
    logic tx_done_c;

    // State register
    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            copy_q     <= '0;
            bit_cnt_q  <= '0;
            led_cnt_q  <= '0;
            lat_cnt_q  <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            copy_q     <= copy_d;
            bit_cnt_q  <= bit_cnt_d;
            led_cnt_q  <= led_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign accept_c = bus.in_valid && in_ready_q;

    // Next-state: capture, bit/LED sequencing, latch timing
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        copy_d     = copy_q;
        bit_cnt_d  = bit_cnt_q;
        led_cnt_d  = led_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        tx_start_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    copy_d     = '{green: bus.green, red: bus.red, blue: bus.blue};
                    shreg_d    = copy_d;
                    bit_cnt_d  = '0;
                    led_cnt_d  = '0;
                    tx_start_c = 1'b1;
                    state_d    = SEND;
                end
            end

            SEND: begin
                if (tx_done_c) begin
                    if (bit_cnt_q == BIT_W'(BITS_PER_LED - 1)) begin
                        bit_cnt_d = '0;
                        if (led_cnt_q < LED_W'(NUM_LEDS - 1)) begin
                            // Next LED follows with no gap
                            led_cnt_d  = led_cnt_q + 1'b1;
                            shreg_d    = copy_q;
                            tx_start_c = 1'b1;
                        end else begin
                            lat_cnt_d = '0;
                            state_d   = LATCH;
                        end
                    end else begin
                        shreg_d    = shreg_q << 1;
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        tx_start_c = 1'b1;
                    end
                end
            end

            LATCH: begin
                if (lat_cnt_q == CNT_W'(TLATCH - 1)) begin
                    state_d = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    ws2812_bit_tx #(
        .T0H   (T0H),
        .T1H   (T1H),
        .TBIT  (TBIT),
        .CNT_W (CNT_W)
    ) u_bit_tx (
        .clk12MHz (clk12MHz),
        .reset    (reset),
        .start    (tx_start_c),
        .bit_val  (shreg_d[BITS_PER_LED-1]),
        .done_c   (tx_done_c),
        .dout     (dout)
    );

    assign bus.in_ready = in_ready_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_ws2812_driver.sv
// tb_ws2812_driver: scoreboard bench. Stimulus pushes the expected GRB bit
// stream per accepted frame; a monitor decodes dout bit by bit and compares
// each completed frame and its latch length against the queue.
module tb_ws2812_driver;

    localparam int T0H    = 5;
    localparam int T1H    = 10;
    localparam int TBIT   = 15;
    localparam int TLATCH = 3600;

    typedef struct {
        logic [71:0] d;
        int          n;
    } exp_t;

    logic clk;
    logic rst_a, rst_b;
    logic dout_a, busy_a, dout_b, busy_b;

    ws2812_if bus_a ();
    ws2812_if bus_b ();

    ws2812_driver #(.NUM_LEDS(1)) dut_a (
        .clk12MHz (clk),
        .reset    (rst_a),
        .bus      (bus_a),
        .dout     (dout_a),
        .busy     (busy_a)
    );

    ws2812_driver #(.NUM_LEDS(3)) dut_b (
        .clk12MHz (clk),
        .reset    (rst_b),
        .bus      (bus_b),
        .dout     (dout_b),
        .busy     (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    exp_t q0[$];
    exp_t q1[$];

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic pop_exp(input int m, output exp_t e, output bit ok);
        ok = 1'b0;
        e.d = '0;
        e.n = 0;
        if (m == 0 && q0.size() > 0) begin
            e = q0.pop_front();
            ok = 1'b1;
        end else if (m == 1 && q1.size() > 0) begin
            e = q1.pop_front();
            ok = 1'b1;
        end
    endtask

    // Monitor state per DUT
    bit          in_frame [2];
    bit          in_lat   [2];
    bit          fell     [2];
    bit          bad_shape[2];
    bit          lat_hi   [2];
    int          per      [2];
    int          hi       [2];
    int          nb       [2];
    int          lat      [2];
    logic [71:0] bits     [2];

    task automatic step_bit(input int m, input logic d);
        if (d) begin
            if (fell[m]) bad_shape[m] = 1'b1;
            hi[m]++;
        end else begin
            fell[m] = 1'b1;
        end
        if (per[m] == TBIT - 1) begin
            if (hi[m] != T0H && hi[m] != T1H) bad_shape[m] = 1'b1;
            bits[m] = {bits[m][70:0], (hi[m] == T1H)};
            nb[m]++;
            per[m]  = 0;
            hi[m]   = 0;
            fell[m] = 1'b0;
            if (nb[m] > 80) begin
                chk("frame_runaway", 72'(nb[m]), 72'd72);
                in_frame[m] = 1'b0;
            end
        end else begin
            per[m]++;
        end
    endtask

    task automatic mon_step(input int m, input logic rst, input logic d, input logic rdy);
        exp_t e;
        bit   ok;
        if (rst) begin
            if (in_frame[m]) pop_exp(m, e, ok);  // abandoned frame
            in_frame[m] = 1'b0;
            in_lat[m]   = 1'b0;
        end else if (in_lat[m]) begin
            if (d) lat_hi[m] = 1'b1;
            if (rdy) begin
                chk("latch_len", 72'(lat[m]), 72'(TLATCH));
                chk("latch_low", 72'(lat_hi[m]), 72'd0);
                in_lat[m] = 1'b0;
            end else begin
                lat[m]++;
            end
        end else if (!in_frame[m]) begin
            if (d) begin
                in_frame[m]  = 1'b1;
                per[m]       = 0;
                hi[m]        = 0;
                nb[m]        = 0;
                bits[m]      = '0;
                fell[m]      = 1'b0;
                bad_shape[m] = 1'b0;
                step_bit(m, d);
            end
        end else if (per[m] == 0 && !d) begin
            pop_exp(m, e, ok);
            if (!ok) begin
                chk("frame_unexpected", 72'd1, 72'd0);
            end else begin
                chk("frame_bits", 72'(nb[m]), 72'(e.n));
                chk("frame_data", bits[m], e.d);
                chk("bit_shape", 72'(bad_shape[m]), 72'd0);
            end
            in_frame[m] = 1'b0;
            in_lat[m]   = 1'b1;
            lat[m]      = 1;
            lat_hi[m]   = 1'b0;
        end else begin
            step_bit(m, d);
        end
    endtask

    always @(posedge clk) begin
        #1;
        mon_step(0, rst_a, dout_a, bus_a.in_ready);
        mon_step(1, rst_b, dout_b, bus_b.in_ready);
    end

    function automatic logic get_rdy(input int m);
        return (m == 0) ? bus_a.in_ready : bus_b.in_ready;
    endfunction

    task automatic drive(input int m, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b, input logic v);
        if (m == 0) begin
            bus_a.red = r; bus_a.green = g; bus_a.blue = b; bus_a.in_valid = v;
        end else begin
            bus_b.red = r; bus_b.green = g; bus_b.blue = b; bus_b.in_valid = v;
        end
    endtask

    task automatic set_valid(input int m, input logic v);
        if (m == 0) bus_a.in_valid = v;
        else        bus_b.in_valid = v;
    endtask

    // Present a colour, wait for acceptance, push its expected stream
    task automatic send(input int m, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        exp_t e;
        int   leds;
        int   k;
        leds = (m == 0) ? 1 : 3;
        e.n = 24 * leds;
        e.d = '0;
        for (int i = 0; i < leds; i++) e.d = {e.d[47:0], g, r, b};
        @(negedge clk);
        drive(m, r, g, b, 1'b1);
        k = 0;
        while (!get_rdy(m) && k < 6000) begin
            @(negedge clk);
            k++;
        end
        if (!get_rdy(m)) begin
            chk("accept_timeout", 72'd0, 72'd1);
            set_valid(m, 1'b0);
            return;
        end
        if (m == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(negedge clk);
        set_valid(m, 1'b0);
        chk("first_high", 72'((m == 0) ? dout_a : dout_b), 72'd1);
        chk("busy_send", 72'((m == 0) ? busy_a : busy_b), 72'd1);
        chk("ready_send", 72'(get_rdy(m)), 72'd0);
    endtask

    // Count negedges until in_ready; check the count when want > 0
    task automatic wait_ready(input int m, input int want);
        int n;
        n = 0;
        while (n < 10000) begin
            @(negedge clk);
            n++;
            if (get_rdy(m)) break;
        end
        if (!get_rdy(m)) chk("ready_timeout", 72'd0, 72'd1);
        else if (want > 0) chk("accept_to_ready", 72'(n), 72'(want));
    endtask

    initial begin
        #700000;
        $display("FAIL watchdog expired");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        drive(0, 8'h00, 8'h00, 8'h00, 1'b0);
        drive(1, 8'h00, 8'h00, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Idle after reset
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_dout", 72'(dout_a), 72'd0);
            chk("idle_ready", 72'(bus_a.in_ready), 72'd1);
            chk("idle_busy", 72'(busy_a), 72'd0);
        end

        // Green full on: 8 ones then 16 zeros; 360 + 3600 + 1
        send(0, 8'h00, 8'hFF, 8'h00);
        wait_ready(0, 3961 - 1);

        // Mixed pattern GRB = 0x3CA581
        send(0, 8'hA5, 8'h3C, 8'h81);
        wait_ready(0, 3960);

        // Inputs disturbed during SEND and LATCH are ignored
        send(0, 8'h11, 8'h22, 8'h33);
        repeat (50) @(negedge clk);
        drive(0, 8'hEE, 8'hEE, 8'hEE, 1'b1);
        @(negedge clk);
        chk("ready_in_send", 72'(bus_a.in_ready), 72'd0);
        set_valid(0, 1'b0);
        repeat (400) @(negedge clk);
        drive(0, 8'h77, 8'h77, 8'h77, 1'b1);
        @(negedge clk);
        chk("ready_in_latch", 72'(bus_a.in_ready), 72'd0);
        chk("dout_in_latch", 72'(dout_a), 72'd0);
        set_valid(0, 1'b0);
        wait_ready(0, 0);
        send(0, 8'h5A, 8'hA5, 8'hC3);
        wait_ready(0, 3960);

        // Reset during bit 10, then a clean frame
        send(0, 8'hF0, 8'h0F, 8'hAA);
        repeat (153) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        chk("rst_dout", 72'(dout_a), 72'd0);
        chk("rst_ready", 72'(bus_a.in_ready), 72'd1);
        chk("rst_busy", 72'(busy_a), 72'd0);
        rst_a = 1'b0;
        send(0, 8'hC3, 8'h3C, 8'h99);
        wait_ready(0, 3960);

        // Three LEDs, colour R=12 G=34 B=56: 1080 + 3600 + 1
        send(1, 8'h12, 8'h34, 8'h56);
        wait_ready(1, 4680);

        repeat (5) @(negedge clk);
        chk("sb_empty_a", 72'(q0.size()), 72'd0);
        chk("sb_empty_b", 72'(q1.size()), 72'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
